// File: rtl/status_led_driver.sv
// Debounced, sticky pass/fail indicator for the calc self-check verdict.
// Blue blink while settling, green breathing PWM on pass, red latched blink on failure.
module status_led_driver #(
  parameter int PWM_BITS     = 8,
  parameter int STEP_DIV     = 46875,
  parameter int BLINK_DIV    = 6000000,
  parameter int PASS_CONFIRM = 1024,
  parameter int INIT_TIMEOUT = 24000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       correct,
  input  logic       clear,
  output logic       led_red_n,
  output logic       led_grn_n,
  output logic       led_blu_n,
  output logic [1:0] state,
  output logic [7:0] fail_count
);

  localparam int CW = $clog2(PASS_CONFIRM + 1);
  localparam int TW = $clog2(INIT_TIMEOUT + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam int SW = $clog2(STEP_DIV + 1);

  localparam logic [CW-1:0]       CONFIRM_MAX = CW'(PASS_CONFIRM);
  localparam logic [TW-1:0]       TIMEOUT_MAX = TW'(INIT_TIMEOUT);
  localparam logic [BW-1:0]       BLINK_LAST  = BW'(BLINK_DIV - 1);
  localparam logic [SW-1:0]       STEP_LAST   = SW'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] BRIGHT_MAX  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] BRIGHT_ONE  = PWM_BITS'(1);

  typedef enum logic [1:0] {
    ST_INIT = 2'b00,
    ST_PASS = 2'b01,
    ST_FAIL = 2'b10
  } state_t;

  state_t st_q, st_d;
  logic   entry;

  logic sync_p0, corr_s;

  logic [CW-1:0]       confirm_cnt;
  logic [TW-1:0]       timeout_cnt;
  logic [BW-1:0]       blink_cnt;
  logic                blink_ph;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] bright;
  logic                dir_up;
  logic [SW-1:0]       step_cnt;

  assign state = st_q;

  // Stage p0/p1: two-flop synchronizer for the asynchronous verdict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      corr_s  <= 1'b0;
    end else begin
      sync_p0 <= correct;
      corr_s  <= sync_p0;
    end
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_INIT: begin
        if (confirm_cnt >= CONFIRM_MAX)      st_d = ST_PASS;
        else if (timeout_cnt >= TIMEOUT_MAX) st_d = ST_FAIL;
      end
      ST_PASS: if (!corr_s) st_d = ST_FAIL;
      ST_FAIL: st_d = ST_FAIL;
      default: st_d = ST_INIT;
    endcase
    if (clear) st_d = ST_INIT;
    entry = clear || (st_d != st_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= ST_INIT;
      fail_count <= 8'd0;
    end else begin
      st_q <= st_d;
      if (st_d == ST_FAIL && st_q != ST_FAIL && fail_count != 8'hFF)
        fail_count <= fail_count + 8'd1;
    end
  end

  // Settling counters only run in INIT; every other path into INIT is via clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      confirm_cnt <= '0;
      timeout_cnt <= '0;
    end else if (clear || st_q != ST_INIT) begin
      confirm_cnt <= '0;
      timeout_cnt <= '0;
    end else begin
      if (!corr_s)                        confirm_cnt <= '0;
      else if (confirm_cnt < CONFIRM_MAX) confirm_cnt <= confirm_cnt + 1'b1;
      if (timeout_cnt < TIMEOUT_MAX)      timeout_cnt <= timeout_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b1;
    end else if (entry) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_ph  <= ~blink_ph;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Triangle brightness: direction flips on reaching either end value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt  <= '0;
      bright   <= '0;
      dir_up   <= 1'b1;
      step_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (entry) begin
        bright   <= '0;
        dir_up   <= 1'b1;
        step_cnt <= '0;
      end else if (st_q == ST_PASS) begin
        if (step_cnt == STEP_LAST) begin
          step_cnt <= '0;
          if (dir_up) begin
            bright <= bright + 1'b1;
            if (bright == BRIGHT_MAX - BRIGHT_ONE) dir_up <= 1'b0;
          end else begin
            bright <= bright - 1'b1;
            if (bright == BRIGHT_ONE) dir_up <= 1'b1;
          end
        end else begin
          step_cnt <= step_cnt + 1'b1;
        end
      end
    end
  end

  // Output stage: LEDs registered one cycle behind state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_red_n <= 1'b1;
      led_grn_n <= 1'b1;
      led_blu_n <= 1'b1;
    end else begin
      led_red_n <= !(st_q == ST_FAIL && blink_ph);
      led_grn_n <= !(st_q == ST_PASS && (pwm_cnt < bright));
      led_blu_n <= !(st_q == ST_INIT && blink_ph);
    end
  end

endmodule

// File: tb/tb_status_led_driver.sv
// Directed bench for status_led_driver with small parameters and hand-derived expectations.
module tb_status_led_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       correct;
  logic       clear;
  logic       led_red_n, led_grn_n, led_blu_n;
  logic [1:0] state;
  logic [7:0] fail_count;

  int n_chk  = 0;
  int n_fail = 0;

  status_led_driver #(
    .PWM_BITS    (3),
    .STEP_DIV    (2),
    .BLINK_DIV   (4),
    .PASS_CONFIRM(5),
    .INIT_TIMEOUT(20)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .correct   (correct),
    .clear     (clear),
    .led_red_n (led_red_n),
    .led_grn_n (led_grn_n),
    .led_blu_n (led_blu_n),
    .state     (state),
    .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset, then release on a falling edge; the next rising edge is edge 1
  task automatic do_reset(input logic corr_val);
    rst_n   = 1'b0;
    clear   = 1'b0;
    correct = corr_val;
    ticks(2);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int tri_b(input int j);
    int k;
    k = j % 14;
    return (k <= 7) ? k : 14 - k;
  endfunction

  task automatic wait_state(input logic [1:0] s, input int maxc, input string tag);
    int c;
    c = 0;
    while (state !== s && c < maxc) begin
      ticks(1);
      c++;
    end
    chk(tag, state, s);
  endtask

  initial begin
    logic exp_g;
    rst_n   = 1'b0;
    correct = 1'b0;
    clear   = 1'b0;

    // Reset values with clock running, then blue blink and timeout
    ticks(3);
    chk("rst_leds", {led_red_n, led_grn_n, led_blu_n}, 3'b111);
    chk("rst_state", state, 2'b00);
    chk("rst_fcnt", fail_count, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      ticks(1);
      chk($sformatf("blue_e%0d", e), led_blu_n, (e <= 4) ? 1'b0 : 1'b1);
    end
    chk("init_red_off", led_red_n, 1'b1);
    chk("init_grn_off", led_grn_n, 1'b1);
    ticks(12);
    chk("to_state_e20", state, 2'b00);
    ticks(1);
    chk("to_state_e21", state, 2'b10);
    chk("to_fcnt", fail_count, 8'd1);
    ticks(1);
    chk("to_red_on", led_red_n, 1'b0);
    chk("to_blu_off", led_blu_n, 1'b1);

    // Confirm and breathe
    do_reset(1'b1);
    ticks(7);
    chk("cf_state_e7", state, 2'b00);
    ticks(1);
    chk("cf_state_e8", state, 2'b01);
    for (int e = 9; e <= 40; e++) begin
      ticks(1);
      exp_g = (((e - 1) % 8) < tri_b((e - 9) / 2)) ? 1'b0 : 1'b1;
      chk($sformatf("grn_e%0d", e), led_grn_n, exp_g);
    end
    chk("pass_blu_off", led_blu_n, 1'b1);
    chk("pass_red_off", led_red_n, 1'b1);

    // Glitch during INIT, then timeout
    do_reset(1'b1);
    for (int e = 1; e <= 20; e++) begin
      ticks(1);
      correct = (e <= 3 || (e >= 5 && e <= 8)) ? 1'b1 : 1'b0;
      if (e == 9 || e == 20) chk($sformatf("gl_state_e%0d", e), state, 2'b00);
    end
    ticks(1);
    chk("gl_state_e21", state, 2'b10);
    chk("gl_fcnt", fail_count, 8'd1);
    ticks(1);
    chk("gl_red_e22", led_red_n, 1'b0);
    ticks(4);
    chk("gl_red_e26", led_red_n, 1'b1);

    // PASS to FAIL, clear, PASS to FAIL again
    do_reset(1'b1);
    ticks(10);
    chk("pf_pass", state, 2'b01);
    correct = 1'b0;
    ticks(1);
    correct = 1'b1;
    ticks(1);
    chk("pf_state_e12", state, 2'b01);
    ticks(1);
    chk("pf_state_e13", state, 2'b10);
    ticks(7);
    chk("pf_sticky", state, 2'b10);
    chk("pf_fcnt1", fail_count, 8'd1);
    clear = 1'b1;
    ticks(1);
    clear = 1'b0;
    chk("pf_clr_state", state, 2'b00);
    chk("pf_clr_fcnt", fail_count, 8'd1);
    ticks(1);
    chk("pf_clr_blu", led_blu_n, 1'b0);
    ticks(4);
    chk("pf_state_e26", state, 2'b00);
    ticks(1);
    chk("pf_state_e27", state, 2'b01);
    correct = 1'b0;
    ticks(1);
    correct = 1'b1;
    ticks(2);
    chk("pf_refail", state, 2'b10);
    chk("pf_fcnt2", fail_count, 8'd2);

    // Priority: clear against PASS confirm
    do_reset(1'b1);
    ticks(7);
    clear = 1'b1;
    ticks(1);
    clear = 1'b0;
    chk("pr_clear_win", state, 2'b00);
    ticks(1);
    chk("pr_clear_hold", state, 2'b00);

    // Priority: confirm and timeout coincide
    do_reset(1'b0);
    ticks(13);
    correct = 1'b1;
    ticks(7);
    chk("pr_both_e20", state, 2'b00);
    ticks(1);
    chk("pr_both_e21", state, 2'b01);
    chk("pr_both_fcnt", fail_count, 8'd0);

    // Saturation via timeout/clear loops
    do_reset(1'b0);
    for (int i = 0; i < 260; i++) begin
      wait_state(2'b10, 40, "sat_wait");
      if (i < 259) begin
        clear = 1'b1;
        ticks(1);
        clear = 1'b0;
      end
    end
    chk("sat_fcnt", fail_count, 8'd255);
    ticks(1);
    chk("sat_red_on", led_red_n, 1'b0);

    // Asynchronous reset mid-period
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_leds", {led_red_n, led_grn_n, led_blu_n}, 3'b111);
    chk("ar_state", state, 2'b00);
    chk("ar_fcnt", fail_count, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
